axi4_lite_master_ctrl: RTL

AXI4_LITE_MASTER_CTRL -- requirements
Module: axi4_lite_master_ctrl

---
 rtl/axi4_lite_master_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite master controller with independent write and read engines.
//
// Write: a start pulse in idle registers address/data/strobes and issues AW and W,
// which complete independently; the B response is then awaited. Read: a start pulse
// registers the address, issues AR, then awaits R. Each engine has its own timeout
// counter; on expiry it abandons the transaction and reports RESP=2'b10 with a
// DONE+TOUT pulse.
//
// Ports:
//   iCLK, iRST                      clock (rising), async active-low reset
//   iWRITE_START/ADDR/DATA/STRB     write request
//   iREAD_START/ADDR                read request
//   oWRITE_BUSY/DONE/RESP/TOUT      write status
//   oREAD_BUSY/DONE/DATA/RESP/TOUT  read status
//   m_AW*, m_W*, m_B*, m_AR*, m_R*  AXI4-Lite master channels
module axi4_lite_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256,
  parameter logic [2:0]  PROT    = 3'b000
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iWRITE_START,
  input  logic [ADDR_W-1:0]   iWRITE_ADDR,
  input  logic [DATA_W-1:0]   iWRITE_DATA,
  input  logic [DATA_W/8-1:0] iWRITE_STRB,
  input  logic                iREAD_START,
  input  logic [ADDR_W-1:0]   iREAD_ADDR,
  output logic                oWRITE_BUSY,
  output logic                oWRITE_DONE,
  output logic [1:0]          oWRITE_RESP,
  output logic                oWRITE_TOUT,
  output logic                oREAD_BUSY,
  output logic                oREAD_DONE,
  output logic [DATA_W-1:0]   oREAD_DATA,
  output logic [1:0]          oREAD_RESP,
  output logic                oREAD_TOUT,
  output logic                m_AWVALID,
  input  logic                m_AWREADY,
  output logic [ADDR_W-1:0]   m_AWADDR,
  output logic [2:0]          m_AWPROT,
  output logic                m_WVALID,
  input  logic                m_WREADY,
  output logic [DATA_W-1:0]   m_WDATA,
  output logic [DATA_W/8-1:0] m_WSTRB,
  input  logic                m_BVALID,
  output logic                m_BREADY,
  input  logic [1:0]          m_BRESP,
  output logic                m_ARVALID,
  input  logic                m_ARREADY,
  output logic [ADDR_W-1:0]   m_ARADDR,
  output logic [2:0]          m_ARPROT,
  input  logic                m_RVALID,
  output logic                m_RREADY,
  input  logic [DATA_W-1:0]   m_RDATA,
  input  logic [1:0]          m_RRESP
);

  localparam int unsigned StrbW     = DATA_W / 8;
  localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT > 0);
  localparam logic [CntW-1:0] CntMax  = TimeoutEn ? CntW'(TIMEOUT) : '0;
  // Expiry is flagged in the TIMEOUT-th busy cycle so the FSM is idle right after it.
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StWIdle, StWReq, StWResp} wr_state_e;
  typedef enum logic [1:0] {StRIdle, StRAddr, StRData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [StrbW-1:0]  wstrb_q;
  logic              aw_hs_q, w_hs_q;
  logic [CntW-1:0]   wr_cnt_q, rd_cnt_q;
  logic              wr_done_q, wr_tout_q, rd_done_q, rd_tout_q;
  logic [1:0]        wr_resp_q, rd_resp_q;

  logic wr_accept, wr_finish, wr_tout, rd_accept, rd_finish, rd_tout;
  logic aw_hs, w_hs, wr_expire, rd_expire;

  assign aw_hs     = (wr_state_q == StWReq) && !aw_hs_q && m_AWREADY;
  assign w_hs      = (wr_state_q == StWReq) && !w_hs_q && m_WREADY;
  assign wr_expire = TimeoutEn && (wr_cnt_q >= CntLast);
  assign rd_expire = TimeoutEn && (rd_cnt_q >= CntLast);

  // State registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_state_q <= StWIdle;
      rd_state_q <= StRIdle;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Write next-state; a completing handshake wins over expiry in the same cycle.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_accept  = 1'b0;
    wr_finish  = 1'b0;
    wr_tout    = 1'b0;
    unique case (wr_state_q)
      StWIdle: begin
        if (iWRITE_START) begin
          wr_state_d = StWReq;
          wr_accept  = 1'b1;
        end
      end
      StWReq: begin
        if ((aw_hs_q || aw_hs) && (w_hs_q || w_hs)) begin
          wr_state_d = StWResp;
        end else if (wr_expire) begin
          wr_state_d = StWIdle;
          wr_tout    = 1'b1;
        end
      end
      StWResp: begin
        if (m_BVALID) begin
          wr_state_d = StWIdle;
          wr_finish  = 1'b1;
        end else if (wr_expire) begin
          wr_state_d = StWIdle;
          wr_tout    = 1'b1;
        end
      end
      default: wr_state_d = StWIdle;
    endcase
  end

  // Read next-state
  always_comb begin
    rd_state_d = rd_state_q;
    rd_accept  = 1'b0;
    rd_finish  = 1'b0;
    rd_tout    = 1'b0;
    unique case (rd_state_q)
      StRIdle: begin
        if (iREAD_START) begin
          rd_state_d = StRAddr;
          rd_accept  = 1'b1;
        end
      end
      StRAddr: begin
        if (m_ARREADY) begin
          rd_state_d = StRData;
        end else if (rd_expire) begin
          rd_state_d = StRIdle;
          rd_tout    = 1'b1;
        end
      end
      StRData: begin
        if (m_RVALID) begin
          rd_state_d = StRIdle;
          rd_finish  = 1'b1;
        end else if (rd_expire) begin
          rd_state_d = StRIdle;
          rd_tout    = 1'b1;
        end
      end
      default: rd_state_d = StRIdle;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    m_AWVALID   = (wr_state_q == StWReq) && !aw_hs_q;
    m_WVALID    = (wr_state_q == StWReq) && !w_hs_q;
    m_BREADY    = (wr_state_q == StWResp);
    m_ARVALID   = (rd_state_q == StRAddr);
    m_RREADY    = (rd_state_q == StRData);
    m_AWADDR    = aw_addr_q;
    m_AWPROT    = PROT;
    m_WDATA     = wdata_q;
    m_WSTRB     = wstrb_q;
    m_ARADDR    = ar_addr_q;
    m_ARPROT    = PROT;
    oWRITE_BUSY = (wr_state_q != StWIdle);
    oWRITE_DONE = wr_done_q;
    oWRITE_RESP = wr_resp_q;
    oWRITE_TOUT = wr_tout_q;
    oREAD_BUSY  = (rd_state_q != StRIdle);
    oREAD_DONE  = rd_done_q;
    oREAD_DATA  = rdata_q;
    oREAD_RESP  = rd_resp_q;
    oREAD_TOUT  = rd_tout_q;
  end

  // Write datapath, handshake flags and timeout counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_hs_q   <= 1'b0;
      w_hs_q    <= 1'b0;
      wr_cnt_q  <= '0;
      wr_done_q <= 1'b0;
      wr_tout_q <= 1'b0;
      wr_resp_q <= 2'b00;
    end else begin
      wr_done_q <= wr_finish || wr_tout;
      wr_tout_q <= wr_tout;
      if (wr_accept) begin
        aw_addr_q <= iWRITE_ADDR;
        wdata_q   <= iWRITE_DATA;
        wstrb_q   <= iWRITE_STRB;
        aw_hs_q   <= 1'b0;
        w_hs_q    <= 1'b0;
        wr_cnt_q  <= '0;
      end else if (wr_state_q != StWIdle) begin
        if (aw_hs) aw_hs_q <= 1'b1;
        if (w_hs)  w_hs_q  <= 1'b1;
        if (wr_cnt_q != CntMax) wr_cnt_q <= wr_cnt_q + CntW'(1);
      end
      if (wr_finish) begin
        wr_resp_q <= m_BRESP;
      end else if (wr_tout) begin
        wr_resp_q <= 2'b10;
      end
    end
  end

  // Read datapath and timeout counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rd_cnt_q  <= '0;
      rd_done_q <= 1'b0;
      rd_tout_q <= 1'b0;
      rd_resp_q <= 2'b00;
    end else begin
      rd_done_q <= rd_finish || rd_tout;
      rd_tout_q <= rd_tout;
      if (rd_accept) begin
        ar_addr_q <= iREAD_ADDR;
        rd_cnt_q  <= '0;
      end else if (rd_state_q != StRIdle) begin
        if (rd_cnt_q != CntMax) rd_cnt_q <= rd_cnt_q + CntW'(1);
      end
      if (rd_finish) begin
        rdata_q   <= m_RDATA;
        rd_resp_q <= m_RRESP;
      end else if (rd_tout) begin
        rd_resp_q <= 2'b10;
      end
    end
  end

endmodule
